// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ALU A/B operand and store-data select with a valid/ready handshake.
// Define ALU_OPSEL_FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise register-file data passes through.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [DATA_W-1:0] pc,
    input  logic [1:0]        alu_src_a,
    input  logic              alu_src_b,
    input  logic              exm_wr_en,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] st_data,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);
    logic [DATA_W-1:0] fwd_rs1, fwd_rs2;
    logic [1:0]        sel_rs1, sel_rs2;
    logic              accept;
`ifdef ALU_OPSEL_FWD_EN
    // EX/MEM is younger than MEM/WB, so it wins when both target the same register
    assign sel_rs1 = (exm_wr_en && exm_rd == rs1_addr && |rs1_addr) ? 2'b01 :
                     (wb_wr_en && wb_rd == rs1_addr && |rs1_addr)   ? 2'b10 : 2'b00;
    assign sel_rs2 = (exm_wr_en && exm_rd == rs2_addr && |rs2_addr) ? 2'b01 :
                     (wb_wr_en && wb_rd == rs2_addr && |rs2_addr)   ? 2'b10 : 2'b00;
    assign fwd_rs1 = sel_rs1 == 2'b01 ? exm_data : sel_rs1 == 2'b10 ? wb_data : rs1_data;
    assign fwd_rs2 = sel_rs2 == 2'b01 ? exm_data : sel_rs2 == 2'b10 ? wb_data : rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{exm_wr_en, exm_rd, exm_data, wb_wr_en, wb_rd, wb_data, rs1_addr, rs2_addr};
    assign sel_rs1 = 2'b00;
    assign sel_rs2 = 2'b00;
    assign fwd_rs1 = rs1_data;
    assign fwd_rs2 = rs2_data;
`endif
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            st_data   <= '0;
            fwd_a     <= 2'b00;
            fwd_b     <= 2'b00;
        end else begin
            out_valid <= flush ? 1'b0 : in_ready ? in_valid : out_valid;
            if (accept) begin
                a_out   <= alu_src_a == 2'b00 ? fwd_rs1 : alu_src_a == 2'b01 ? pc : '0;
                b_out   <= alu_src_b ? imm_ext : fwd_rs2;
                st_data <= fwd_rs2;
                fwd_a   <= alu_src_a == 2'b00 ? sel_rs1 : 2'b00;
                fwd_b   <= sel_rs2;
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench for alu_operand_stage; follows ALU_OPSEL_FWD_EN like the design.
module tb_alu_operand_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, exm_rd = '0, wb_rd = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0, imm_ext = '0, pc = '0, exm_data = '0, wb_data = '0;
    logic [1:0]  alu_src_a = '0, fwd_a, fwd_b;
    logic        alu_src_b = 1'b0, exm_wr_en = 1'b0, wb_wr_en = 1'b0;
    logic [31:0] a_out, b_out, st_data;
    int          vectors = 0, miscompares = 0;

    typedef struct packed {
        logic [31:0] a, b, st;
        logic [1:0]  fa, fb;
    } exp_t;
    exp_t q[$];

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm_ext(imm_ext), .pc(pc), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .b_out(b_out),
        .st_data(st_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model();
        exp_t        e;
        logic [31:0] r1 = rs1_data, r2 = rs2_data;
        logic [1:0]  f1 = 2'b00, f2 = 2'b00;
`ifdef ALU_OPSEL_FWD_EN
        if (rs1_addr != 0 && exm_wr_en && exm_rd == rs1_addr) begin r1 = exm_data; f1 = 2'b01; end
        else if (rs1_addr != 0 && wb_wr_en && wb_rd == rs1_addr) begin r1 = wb_data; f1 = 2'b10; end
        if (rs2_addr != 0 && exm_wr_en && exm_rd == rs2_addr) begin r2 = exm_data; f2 = 2'b01; end
        else if (rs2_addr != 0 && wb_wr_en && wb_rd == rs2_addr) begin r2 = wb_data; f2 = 2'b10; end
`endif
        case (alu_src_a)
            2'b00: e.a = r1;
            2'b01: e.a = pc;
            default: e.a = 32'h0;
        endcase
        e.fa = (alu_src_a == 2'b00) ? f1 : 2'b00;
        e.b  = alu_src_b ? imm_ext : r2;
        e.st = r2;
        e.fb = f2;
        return e;
    endfunction

    // Called at a falling edge with inputs already driven; advances one clock.
    task automatic cycle();
        exp_t e;
        logic rdy;
        #1;
        rdy = (q.size() == 0) || out_ready;
        check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            e = q[0];
            check("a_out", a_out, e.a);
            check("b_out", b_out, e.b);
            check("st_data", st_data, e.st);
            check("fwd_a", {30'b0, fwd_a}, {30'b0, e.fa});
            check("fwd_b", {30'b0, fwd_b}, {30'b0, e.fb});
            if (out_ready) void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (in_valid && rdy) q.push_back(model());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
        check({tag, "_a"}, a_out, 32'h0);
        check({tag, "_b"}, b_out, 32'h0);
        check({tag, "_st"}, st_data, 32'h0);
        check({tag, "_fwd"}, {28'b0, fwd_a, fwd_b}, 32'h0);
    endtask

    initial begin
        #3;
        check_zero("reset");
        check("reset_in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; rs2_data = 32'h0000000A; imm_ext = 32'hFFFFFFF6; alu_src_b = 1'b0;
        cycle();
        alu_src_b = 1'b1;
        cycle();
        alu_src_b = 1'b0;
        rs1_addr = 5; rs1_data = 32'h11; exm_wr_en = 1; exm_rd = 5; exm_data = 32'h22;
        wb_wr_en = 1; wb_rd = 5; wb_data = 32'h33;
        cycle();
        exm_wr_en = 0;
        cycle();
        rs1_addr = 0;
        cycle();
        rs1_addr = 5; exm_wr_en = 1; rs2_addr = 5; rs2_data = 32'h44; alu_src_b = 1'b1;
        cycle();
        rs2_addr = 0; exm_rd = 0;
        cycle();
        exm_rd = 5; alu_src_a = 2'b01; pc = 32'h00001000;
        cycle();
        alu_src_a = 2'b10;
        cycle();
        alu_src_a = 2'b11;
        cycle();
        alu_src_a = 2'b00; alu_src_b = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs1_data = $urandom; rs2_data = $urandom; pc = $urandom; imm_ext = $urandom;
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rs1_data = $urandom; rs2_data = $urandom; rs1_addr = 5'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        in_valid = 1'b1;
        cycle();
        out_ready = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
            exm_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
            exm_wr_en = 1'($urandom); wb_wr_en = 1'($urandom);
            rs1_data = $urandom; rs2_data = $urandom; imm_ext = $urandom; pc = $urandom;
            exm_data = $urandom; wb_data = $urandom;
            alu_src_a = 2'($urandom); alu_src_b = 1'($urandom);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; pc = 32'hDEADBEEF;
        cycle();
        out_ready = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
